// File: rtl/vram_scan_arbiter_if.sv
// Writer-side handshake into the VRAM scan arbiter write FIFO.
// The writer drives the master modport; the arbiter uses the slave modport.
interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_drop;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready,
        input  wr_drop
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready,
        output wr_drop
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scan-out reads and a FIFO-buffered pixel writer.
// Optional double buffering (two frame banks, swap on vsync) is enabled by defining VRAM_DOUBLE_BUF_EN.
module vram_scan_arbiter #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          vga_clk,
    input  logic                          rst,
    input  logic [9:0]                    pic_x,
    input  logic [9:0]                    pic_y,
    input  logic                          vsync,
    output logic [DATA_W-1:0]             pic_data,
    vram_scan_arbiter_if.slave            wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ram_en,
    output logic                          ram_we,
`ifdef VRAM_DOUBLE_BUF_EN
    output logic [ADDR_W:0]               ram_addr,
`else
    output logic [ADDR_W-1:0]             ram_addr,
`endif
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata
`ifdef VRAM_DOUBLE_BUF_EN
    ,
    input  logic                          swap_req,
    output logic                          front_buf,
    output logic                          swap_done
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_RES * V_RES);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              scan_hit;
    logic [ADDR_W-1:0] scan_addr;
    logic              fifo_nonempty;
    logic              push;
    logic              pop;
    logic              head_ok;
    logic              rd_flag;

    assign scan_hit      = (pic_x != 10'h3ff) && (pic_y != 10'h3ff);
    assign scan_addr     = ADDR_W'(pic_y) * ADDR_W'(H_RES) + ADDR_W'(pic_x);
    assign fifo_nonempty = (fifo_level != '0);
    assign wr.wr_ready   = (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push          = wr.wr_valid && wr.wr_ready;
    assign pop           = !scan_hit && fifo_nonempty;
    assign head_ok       = (fifo_addr[rd_ptr] < FRAME_PIX);
    assign pic_data      = rd_flag ? ram_rdata : '0;

    // Storage needs no reset: only the pointers and count define which entries are live.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr.wr_addr;
            fifo_data[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_flag    <= 1'b0;
        end else begin
            rd_flag <= scan_hit;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

`ifdef VRAM_DOUBLE_BUF_EN
    logic fifo_bank [FIFO_DEPTH];
    logic vsync_d;
    logic swap_pend;

    // Writes always target the back buffer as it was when the pixel was accepted.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_bank[wr_ptr] <= ~front_buf;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            front_buf <= 1'b0;
            swap_pend <= 1'b0;
            swap_done <= 1'b0;
            vsync_d   <= 1'b0;
        end else begin
            vsync_d   <= vsync;
            swap_done <= 1'b0;
            if (vsync && !vsync_d && (swap_pend || swap_req)) begin
                front_buf <= ~front_buf;
                swap_pend <= 1'b0;
                swap_done <= 1'b1;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    // Scan wins the port outright; the FIFO only drains in cycles the scan leaves free.
    always_comb begin
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        wr.wr_drop = 1'b0;
        if (!rst) begin
            if (scan_hit) begin
                ram_en = 1'b1;
`ifdef VRAM_DOUBLE_BUF_EN
                ram_addr = {front_buf, scan_addr};
`else
                ram_addr = scan_addr;
`endif
            end else if (pop) begin
                if (head_ok) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = fifo_data[rd_ptr];
`ifdef VRAM_DOUBLE_BUF_EN
                    ram_addr = {fifo_bank[rd_ptr], fifo_addr[rd_ptr]};
`else
                    ram_addr = fifo_addr[rd_ptr];
`endif
                end else begin
                    wr.wr_drop = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Randomized bench for vram_scan_arbiter against a queue/framebuffer reference model.
// Exercises the VRAM_DOUBLE_BUF_EN variant as well when that macro is defined.
module tb_vram_scan_arbiter;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME      = H_RES * V_RES;
`ifdef VRAM_DOUBLE_BUF_EN
    localparam int RAM_AW = ADDR_W + 1;
`else
    localparam int RAM_AW = ADDR_W;
`endif

    logic                          vga_clk = 1'b0;
    logic                          rst;
    logic [9:0]                    pic_x;
    logic [9:0]                    pic_y;
    logic                          vsync;
    logic [DATA_W-1:0]             pic_data;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          ram_en;
    logic                          ram_we;
    logic [RAM_AW-1:0]             ram_addr;
    logic [DATA_W-1:0]             ram_wdata;
    logic [DATA_W-1:0]             ram_rdata;
`ifdef VRAM_DOUBLE_BUF_EN
    logic                          swap_req;
    logic                          front_buf;
    logic                          swap_done;
`endif

    vram_scan_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    always #5 vga_clk = ~vga_clk;

    vram_scan_arbiter #(
        .H_RES(H_RES), .V_RES(V_RES), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .pic_x      (pic_x),
        .pic_y      (pic_y),
        .vsync      (vsync),
        .pic_data   (pic_data),
        .wr         (wr_if.slave),
        .fifo_level (fifo_level),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef VRAM_DOUBLE_BUF_EN
        ,
        .swap_req   (swap_req),
        .front_buf  (front_buf),
        .swap_done  (swap_done)
`endif
    );

    // Single-port synchronous RAM; non-read cycles return noise so ungated pic_data shows up.
    logic [DATA_W-1:0] vram [0:(1<<RAM_AW)-1] = '{default: '0};
    always @(posedge vga_clk) begin
        if (ram_en && ram_we) vram[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= vram[ram_addr];
        else ram_rdata <= DATA_W'($urandom);
    end

    typedef struct { int addr; int data; int bank; } ent_t;
    ent_t              m_q[$];
    logic [DATA_W-1:0] m_frame [int];
    bit                m_prev_hit;
    int                m_prev_val;
    bit                m_front, m_pend, m_vs, m_done;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt, acc_cnt;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int full_addr(int bank, int a);
        return (bank << ADDR_W) | a;
    endfunction

    function automatic int frame_rd(int a);
        return m_frame.exists(a) ? int'(m_frame[a]) : 0;
    endfunction

    function automatic bit cur_hit();
        return (pic_x != 10'h3ff) && (pic_y != 10'h3ff);
    endfunction

    function automatic int cur_scan_addr();
        return full_addr(int'(m_front), int'(pic_y) * H_RES + int'(pic_x));
    endfunction

    task automatic check_outputs();
        bit hit;
        hit = cur_hit();
        chk("level", 32'(fifo_level), 32'(m_q.size()));
        chk("ready", 32'(wr_if.wr_ready), 32'(m_q.size() < FIFO_DEPTH));
        chk("pic_data", 32'(pic_data), m_prev_hit ? 32'(m_prev_val) : 32'd0);
        if (rst || (!hit && m_q.size() == 0)) begin
            chk("en", 32'(ram_en), 0);
            chk("we", 32'(ram_we), 0);
            chk("drop", 32'(wr_if.wr_drop), 0);
        end else if (hit) begin
            chk("en", 32'(ram_en), 1);
            chk("we", 32'(ram_we), 0);
            chk("rd_addr", 32'(ram_addr), 32'(cur_scan_addr()));
            chk("drop", 32'(wr_if.wr_drop), 0);
        end else if (m_q[0].addr < FRAME) begin
            chk("en", 32'(ram_en), 1);
            chk("we", 32'(ram_we), 1);
            chk("wr_addr", 32'(ram_addr), 32'(full_addr(m_q[0].bank, m_q[0].addr)));
            chk("wr_data", 32'(ram_wdata), 32'(m_q[0].data));
            chk("drop", 32'(wr_if.wr_drop), 0);
        end else begin
            chk("en", 32'(ram_en), 0);
            chk("drop", 32'(wr_if.wr_drop), 1);
        end
`ifdef VRAM_DOUBLE_BUF_EN
        chk("front_buf", 32'(front_buf), 32'(m_front));
        chk("swap_done", 32'(swap_done), 32'(m_done));
`endif
    endtask

    task automatic model_update();
        bit   hit;
        int   n;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_prev_hit = 0;
            m_front = 0; m_pend = 0; m_vs = 0; m_done = 0;
            return;
        end
        hit = cur_hit();
        n = m_q.size();
        m_prev_hit = hit;
        if (hit) m_prev_val = frame_rd(cur_scan_addr());
        if (!hit && n > 0) begin
            e = m_q.pop_front();
            if (e.addr < FRAME) m_frame[full_addr(e.bank, e.addr)] = DATA_W'(e.data);
        end
        if (wr_if.wr_valid && n < FIFO_DEPTH) begin
`ifdef VRAM_DOUBLE_BUF_EN
            m_q.push_back('{addr: int'(wr_if.wr_addr), data: int'(wr_if.wr_data), bank: int'(!m_front)});
`else
            m_q.push_back('{addr: int'(wr_if.wr_addr), data: int'(wr_if.wr_data), bank: 0});
`endif
        end
`ifdef VRAM_DOUBLE_BUF_EN
        m_done = 0;
        if (vsync && !m_vs && (m_pend || swap_req)) begin
            m_front = !m_front; m_pend = 0; m_done = 1;
        end else if (swap_req) begin
            m_pend = 1;
        end
        m_vs = vsync;
`endif
    endtask

    task automatic step();
        #2;
        check_outputs();
        if (ram_en && ram_we) we_cnt++;
        if (wr_if.wr_valid && wr_if.wr_ready) acc_cnt++;
        @(posedge vga_clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; pic_x = 10'h3ff; pic_y = 10'h3ff;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = ADDR_W'(1285); wr_if.wr_data = 16'hF800;
`ifdef VRAM_DOUBLE_BUF_EN
        swap_req = 1'b0;
`endif
        @(posedge vga_clk);
        model_update();
        #1;
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(wr_if.wr_ready), 1);
        step();
        chk("rst_pic", 32'(pic_data), 0);

        rst = 1'b0;
        step();
        wr_if.wr_valid = 1'b0;
        #1 chk("rst_release_level", 32'(fifo_level), 1);
        step();

        pic_x = 10'd5; pic_y = 10'd2;
        #1;
        chk("scan_en", 32'(ram_en), 1);
        chk("scan_we", 32'(ram_we), 0);
        chk("scan_addr", 32'(ram_addr), 1285);
        step();
        pic_x = 10'h3ff;
        #1 chk("scan_pic", 32'(pic_data), 32'hF800);
        step();
        #1 chk("scan_pic_off", 32'(pic_data), 0);

        // Fill under continuous scan, then drain once scan releases the port.
        pic_x = 10'd1; pic_y = 10'd1;
        wr_if.wr_valid = 1'b1; we_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wr_if.wr_addr = ADDR_W'($urandom_range(0, FRAME - 1));
            wr_if.wr_data = DATA_W'($urandom);
            step();
        end
        #1;
        chk("fill_accepts", 32'(acc_cnt), 16);
        chk("fill_level", 32'(fifo_level), 16);
        chk("fill_ready", 32'(wr_if.wr_ready), 0);
        chk("fill_no_write", 32'(we_cnt), 0);
        pic_x = 10'h3ff; wr_if.wr_valid = 1'b0; we_cnt = 0;
        repeat (16) step();
        #1;
        chk("drain_writes", 32'(we_cnt), 16);
        chk("drain_level", 32'(fifo_level), 0);

        wr_if.wr_valid = 1'b1; wr_if.wr_addr = ADDR_W'(307199); wr_if.wr_data = 16'h1234;
        step();
        wr_if.wr_addr = ADDR_W'(307200); wr_if.wr_data = 16'h5678;
        #1 chk("bnd_last_we", 32'(ram_we), 1);
        step();
        wr_if.wr_valid = 1'b0;
        #1;
        chk("bnd_over_drop", 32'(wr_if.wr_drop), 1);
        chk("bnd_over_en", 32'(ram_en), 0);
        step();

        pic_x = 10'd0; pic_y = 10'd0; wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_addr = ADDR_W'(i + 10); wr_if.wr_data = DATA_W'(16'hA000 + i);
            step();
        end
        pic_x = 10'h3ff; wr_if.wr_addr = ADDR_W'(13); wr_if.wr_data = 16'hA003;
        #1;
        chk("pp_level_before", 32'(fifo_level), 3);
        chk("pp_we", 32'(ram_we), 1);
        step();
        wr_if.wr_valid = 1'b0;
        #1 chk("pp_level_after", 32'(fifo_level), 3);
        repeat (4) step();

`ifdef VRAM_DOUBLE_BUF_EN
        swap_req = 1'b1;
        step();
        swap_req = 1'b0; pic_x = 10'd3; pic_y = 10'd0; wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_if.wr_addr = ADDR_W'(100 + i); wr_if.wr_data = DATA_W'(16'hB000 + i);
            step();
        end
        wr_if.wr_valid = 1'b0; vsync = 1'b1;
        step();
        #1;
        chk("db_front", 32'(front_buf), 1);
        chk("db_done", 32'(swap_done), 1);
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_if.wr_addr = ADDR_W'(200 + i); wr_if.wr_data = DATA_W'(16'hC000 + i);
            step();
        end
        #1 chk("db_done_pulse", 32'(swap_done), 0);
        wr_if.wr_valid = 1'b0; pic_x = 10'h3ff; vsync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("db_bank", 32'(ram_addr[ADDR_W]), (i < 2) ? 32'd1 : 32'd0);
            step();
        end
`endif

        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                pic_x = 10'h3ff; pic_y = 10'($urandom_range(0, 3));
            end else if (r == 1) begin
                pic_x = 10'($urandom_range(0, 7)); pic_y = 10'h3ff;
            end else begin
                pic_x = 10'($urandom_range(0, 7)); pic_y = 10'($urandom_range(0, 3));
            end
            wr_if.wr_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            if (r == 0) wr_if.wr_addr = ADDR_W'(FRAME + $urandom_range(0, 1000));
            else if (r == 1) wr_if.wr_addr = ADDR_W'($urandom_range(0, FRAME - 1));
            else wr_if.wr_addr = ADDR_W'($urandom_range(0, 3) * H_RES + $urandom_range(0, 7));
            wr_if.wr_data = DATA_W'($urandom);
            if ($urandom_range(0, 19) == 0) vsync = ~vsync;
`ifdef VRAM_DOUBLE_BUF_EN
            swap_req = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
